// File: rtl/fc_layer_controller.sv
// Sequencer for one fully-connected layer: clear, accumulate INPUT_LENGTH words, add bias, hand off result.
// Latency: last word transfer at t -> bias_en_o at t+1 -> valid_o at t+2; period INPUT_LENGTH+3 cycles.
// Backpressure: ready_o only in accumulate phase; valid_o held (accumulators frozen) until ready_i.
module fc_layer_controller #(
    parameter int INPUT_LENGTH = 8,
    parameter int ADDR_WIDTH   = $clog2(INPUT_LENGTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  acc_clear_o,
    output logic                  acc_en_o,
    output logic                  bias_en_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    typedef enum logic [1:0] {
        eCLEAR,
        eACCUM,
        eBIAS,
        eDONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(INPUT_LENGTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] count_r;
    logic                  xfer;

    assign xfer = (state_r == eACCUM) && valid_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= eCLEAR;
            count_r <= '0;
        end else begin
            case (state_r)
                eCLEAR: state_r <= eACCUM;
                eACCUM: begin
                    if (xfer) begin
                        // The only way the counter returns to zero is leaving the accumulate phase.
                        if (count_r == LAST_IDX) begin
                            count_r <= '0;
                            state_r <= eBIAS;
                        end else begin
                            count_r <= count_r + ONE;
                        end
                    end
                end
                eBIAS:  state_r <= eDONE;
                eDONE:  if (ready_i) state_r <= eCLEAR;
                default: state_r <= eCLEAR;
            endcase
        end
    end

    // acc_en_o follows valid_i combinationally so the strobe lands on the transfer cycle.
    assign ready_o     = (state_r == eACCUM);
    assign mem_addr_o  = (state_r == eACCUM) ? count_r : '0;
    assign acc_clear_o = (state_r == eCLEAR);
    assign acc_en_o    = xfer;
    assign bias_en_o   = (state_r == eBIAS);
    assign valid_o     = (state_r == eDONE);

endmodule

// File: tb/tb_fc_layer_controller.sv
// Scoreboard bench for fc_layer_controller: INPUT_LENGTH=8 and INPUT_LENGTH=1 instances.
module tb_fc_layer_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // INPUT_LENGTH=8 instance
    logic       reset_i, valid_i, ready_i;
    logic       ready_o, acc_clear_o, acc_en_o, bias_en_o, valid_o;
    logic [3:0] mem_addr_o;

    // INPUT_LENGTH=1 instance
    logic       reset1, valid1, ready1;
    logic       ready_o1, acc_clear_o1, acc_en_o1, bias_en_o1, valid_o1;
    logic [0:0] mem_addr_o1;

    fc_layer_controller #(.INPUT_LENGTH(8)) u_dut (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o),
        .mem_addr_o(mem_addr_o), .acc_clear_o(acc_clear_o), .acc_en_o(acc_en_o),
        .bias_en_o(bias_en_o), .valid_o(valid_o), .ready_i(ready_i)
    );

    fc_layer_controller #(.INPUT_LENGTH(1)) u_dut1 (
        .clk_i(clk), .reset_i(reset1), .valid_i(valid1), .ready_o(ready_o1),
        .mem_addr_o(mem_addr_o1), .acc_clear_o(acc_clear_o1), .acc_en_o(acc_en_o1),
        .bias_en_o(bias_en_o1), .valid_o(valid_o1), .ready_i(ready1)
    );

    typedef struct packed {
        logic       rdy;
        logic [3:0] addr;
        logic       clr;
        logic       en;
        logic       bias;
        logic       vld;
    } obs_t;

    obs_t  sb0[$];
    obs_t  sb1[$];
    obs_t  e0, g0, e1, g1;
    int    checks = 0;
    int    errors = 0;
    string cur_tag = "reset";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic obs_t mk(input logic rdy, input logic [3:0] addr, input logic clr,
                                input logic en, input logic bias, input logic vld);
        obs_t o;
        o = '{rdy, addr, clr, en, bias, vld};
        return o;
    endfunction

    function automatic obs_t e_clr();  return mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0); endfunction
    function automatic obs_t e_bias(); return mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0); endfunction
    function automatic obs_t e_done(); return mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1); endfunction
    function automatic obs_t e_acc(input int k, input logic v);
        return mk(1'b1, 4'(k), 1'b0, v, 1'b0, 1'b0);
    endfunction

    // Expected outputs are queued as each cycle's stimulus is applied, and retired mid-cycle.
    always @(negedge clk) begin
        if (sb0.size() > 0) begin
            e0 = sb0.pop_front();
            g0 = '{ready_o, mem_addr_o, acc_clear_o, acc_en_o, bias_en_o, valid_o};
            check({cur_tag, "_il8"}, 32'(g0), 32'(e0));
            check("excl_il8", 32'(($countones({acc_clear_o, acc_en_o, bias_en_o}) <= 1)
                                 && !(ready_o && valid_o)), 32'd1);
        end
        if (sb1.size() > 0) begin
            e1 = sb1.pop_front();
            g1 = '{ready_o1, {3'b000, mem_addr_o1}, acc_clear_o1, acc_en_o1, bias_en_o1, valid_o1};
            check({cur_tag, "_il1"}, 32'(g1), 32'(e1));
            check("excl_il1", 32'(($countones({acc_clear_o1, acc_en_o1, bias_en_o1}) <= 1)
                                 && !(ready_o1 && valid_o1)), 32'd1);
        end
    end

    task automatic drv(input logic v, input logic r, input obs_t e);
        valid_i = v;
        ready_i = r;
        sb0.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drv1(input logic v, input logic r, input obs_t e);
        valid1 = v;
        ready1 = r;
        sb1.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        valid_i = 1'b1;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
    endtask

    // Feed eight words; bubbly inserts two idle cycles after every valid one.
    task automatic run_accum(input bit bubbly);
        int   k;
        int   j;
        logic v;
        k = 0;
        j = 0;
        while (k < 8) begin
            v = bubbly ? logic'((j % 3) == 0) : 1'b1;
            drv(v, 1'b1, e_acc(k, v));
            if (v) k++;
            j++;
        end
    endtask

    initial begin
        reset_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
        reset1  = 1'b1; valid1  = 1'b0; ready1  = 1'b0;

        cur_tag = "full_rate";
        do_reset();
        drv(1'b1, 1'b1, e_clr());
        run_accum(1'b0);
        drv(1'b1, 1'b1, e_bias());
        drv(1'b1, 1'b1, e_done());
        drv(1'b1, 1'b1, e_clr());
        drv(1'b1, 1'b1, e_acc(0, 1'b1));

        cur_tag = "bubbly";
        do_reset();
        drv(1'b1, 1'b1, e_clr());
        run_accum(1'b1);
        drv(1'b0, 1'b1, e_bias());
        drv(1'b0, 1'b1, e_done());
        drv(1'b0, 1'b1, e_clr());

        cur_tag = "backpressure";
        do_reset();
        drv(1'b1, 1'b1, e_clr());
        run_accum(1'b0);
        drv(1'b1, 1'b0, e_bias());
        for (int i = 0; i < 5; i++) drv(1'b1, 1'b0, e_done());
        drv(1'b1, 1'b1, e_done());
        drv(1'b1, 1'b1, e_clr());
        drv(1'b1, 1'b1, e_acc(0, 1'b1));

        cur_tag = "reset_accum";
        do_reset();
        drv(1'b1, 1'b1, e_clr());
        for (int k = 0; k < 5; k++) drv(1'b1, 1'b1, e_acc(k, 1'b1));
        drv(1'b0, 1'b1, e_acc(5, 1'b0));
        do_reset();
        drv(1'b0, 1'b1, e_clr());
        run_accum(1'b0);
        drv(1'b1, 1'b0, e_bias());
        drv(1'b1, 1'b0, e_done());
        drv(1'b1, 1'b0, e_done());
        cur_tag = "reset_done";
        do_reset();
        drv(1'b1, 1'b1, e_clr());
        drv(1'b1, 1'b1, e_acc(0, 1'b1));

        cur_tag = "len1";
        @(posedge clk);
        #1;
        reset1 = 1'b0;
        drv1(1'b1, 1'b1, e_clr());
        drv1(1'b1, 1'b1, e_acc(0, 1'b1));
        drv1(1'b1, 1'b1, e_bias());
        drv1(1'b1, 1'b1, e_done());
        drv1(1'b1, 1'b1, e_clr());
        drv1(1'b0, 1'b1, e_acc(0, 1'b0));
        drv1(1'b1, 1'b1, e_acc(0, 1'b1));
        drv1(1'b1, 1'b0, e_bias());
        drv1(1'b1, 1'b0, e_done());
        drv1(1'b1, 1'b1, e_done());
        drv1(1'b1, 1'b1, e_clr());

        if (sb0.size() != 0 || sb1.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got=%0d/%0d exp=0/0", sb0.size(), sb1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fc_layer_controller.md
# fc_layer_controller

Sequencer for one fully-connected layer. It accepts a serial input vector of INPUT_LENGTH words and drives the weight-memory address and the accumulator clear/enable/bias strobes of the MAC datapath. When the layer result is complete, it hands the parallel result to fc_output_layer with a valid/ready handshake. It sits between the upstream serial producer (the previous layer or input FIFO) and fc_output_layer, and it also gates the data flow.

## Interface

- INPUT_LENGTH, default 8: number of words per input vector, must be ≥1.
- ADDR_WIDTH, default $clog2(INPUT_LENGTH+1): width of the word index and weight-address bus.

- clk_i  input  1  single clock; all state changes on its rising edge.
- reset_i  input  1  synchronous, active-high reset.
- valid_i  input  1  upstream word valid.
- ready_o  output  1  controller accepts a word this cycle. A transfer occurs when valid_i && ready_o.
- mem_addr_o  output  ADDR_WIDTH  weight-row address, equal to the index of the word being accepted.
- acc_clear_o  output  1  clear all LAYER_HEIGHT accumulators.
- acc_en_o  output  1  accumulate the current input word times the weight row.
- bias_en_o  output  1  add the bias vector into the accumulators.
- valid_o  output  1  accumulator result is valid. Drives valid_i of fc_output_layer.
- ready_i  input  1  downstream ready. Driven from ready_o of fc_output_layer.

## Operation

- The state machine has four states: eCLEAR, eACCUM, eBIAS, eDONE. The state register and word counter reset to eCLEAR and 0.
- eCLEAR:
  - acc_clear_o=1 for exactly one cycle.
  - ready_o=0.
  - Unconditional transition to eACCUM.
- eACCUM:
  - ready_o=1 and mem_addr_o=counter.
  - acc_en_o = valid_i (combinational, so the strobe coincides with the transfer).
  - On each transfer the counter increments.
  - A transfer while counter==INPUT_LENGTH-1 goes to eBIAS and resets the counter to 0.
  - Without valid_i, the state holds and the counter is unchanged. Gaps between words are allowed.
- eBIAS:
  - bias_en_o=1 for one cycle.
  - Unconditional transition to eDONE.
- eDONE:
  - valid_o=1, held until ready_i=1.
  - On valid_o && ready_i the state goes to eCLEAR.
  - While ready_i=0, valid_o stays high with no other strobe. The accumulators are frozen, so the result stays stable.
- Output decode:
  - All outputs are decoded from the registered state and counter, plus valid_i for acc_en_o. There are no output registers.
  - mem_addr_o is 0 outside eACCUM.
  - acc_clear_o, acc_en_o and bias_en_o are never asserted together.
- INPUT_LENGTH=1: the first transfer goes directly to eBIAS.
- Reset mid-operation (any state, any counter value): the next state is eCLEAR with the counter at 0. A partial vector is discarded. A pending valid_o drops in the cycle after the reset edge.

## Timing

- After the reset edge: acc_clear_o=1, and ready_o, acc_en_o, bias_en_o and valid_o are all 0, with mem_addr_o=0. ready_o rises one cycle later.
- If the last word transfers in cycle t, bias_en_o is high in t+1 and valid_o rises in t+2.
- If the downstream handshake completes in cycle d, acc_clear_o is high in d+1 and ready_o is high in d+2.
- Minimum period per vector is INPUT_LENGTH+3 cycles when valid_i and ready_i are held high:
  - INPUT_LENGTH accumulate cycles.
  - One bias cycle.
  - One done cycle.
  - One clear cycle.
- Simultaneous events:
  - valid_i is ignored in eCLEAR, eBIAS and eDONE. Upstream must hold its word (standard valid/ready).
  - ready_i is ignored outside eDONE.
- The counter never exceeds INPUT_LENGTH-1 and never wraps silently. Wrap happens only through the eACCUM→eBIAS transition.

## Test plan

- Reset, then INPUT_LENGTH=8 with valid_i and ready_i held at 1:
  - acc_clear_o in cycle 0.
  - acc_en_o in cycles 1–8 with mem_addr_o=0..7.
  - bias_en_o in cycle 9, valid_o in cycle 10, acc_clear_o in cycle 11.
  - Period is 11 cycles.
- Bubbly input: valid_i toggles 1,0,0,1,… → acc_en_o only on valid cycles. mem_addr_o increments only on transfers. Exactly 8 acc_en_o pulses occur before bias_en_o.
- Backpressure: ready_i=0 for 5 cycles in eDONE → valid_o is held for 6 cycles, ready_o stays 0, and no strobes fire. On ready_i=1, acc_clear_o fires the next cycle.
- Reset at counter=5 in eACCUM, and again with valid_o high in eDONE → the next cycle shows acc_clear_o=1, valid_o=0 and mem_addr_o=0. The following vector completes with 8 fresh accumulate pulses.
- INPUT_LENGTH=1 build: one transfer at mem_addr_o=0, followed by bias_en_o, then valid_o. Period is 4 cycles.
- Assertion on every cycle: at most one of acc_clear_o, acc_en_o and bias_en_o is high, and ready_o and valid_o are never both high.
